shift_pipe_reg: RTL and testbench

SHIFT_PIPE_REG -- requirements
Module: shift_pipe_reg

---
 rtl/shift_pipe_pkg.sv | 13 +
 rtl/shift_pipe_slot.sv | 36 +++
 rtl/shift_pipe_reg.sv | 141 ++++++++++++++
 tb/tb_shift_pipe_reg.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pipe_pkg.sv
// Shared defaults and state encoding for the shift pipeline register.
package shift_pipe_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int SHAMT_W_DEF = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_pipe_slot.sv
// One buffer entry: word, remaining shift bits, registered zero flag, valid.
module shift_pipe_slot
  import shift_pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic [DATA_W-1:0]  load_data,
  input  logic [SHAMT_W-1:0] load_shamt,
  input  logic               load_zero,
  output logic [DATA_W-1:0]  data,
  output logic [SHAMT_W-1:0] shamt,
  output logic               zero,
  output logic               valid
);

  // An empty slot holds all-zero contents so the outputs read 0 while idle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      data  <= '0;
      shamt <= '0;
      zero  <= 1'b0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      shamt <= load_shamt;
      zero  <= load_zero;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/shift_pipe_reg.sv
// Two-entry skid buffer between the 4-bit and 2-bit shifter stages.
// Optional transfer counter enabled by defining SHIFT_PIPE_STATS_EN.
//
// state | meaning
// EMPTY | no slot valid
// ONE   | main slot valid
// FULL  | main and skid slots valid
module shift_pipe_reg
  import shift_pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic               out_zero,
  output logic [15:0]        out_count
);

  state_t state, state_next;

  logic in_xfer, out_xfer;
  logic main_load, main_clear, main_from_skid;
  logic skid_load, skid_clear;
  logic [DATA_W-1:0]  skid_data;
  logic [SHAMT_W-1:0] skid_shamt;
  logic skid_zero, skid_valid;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          main_load  = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_load = 1'b1;
        end else if (in_xfer) begin
          skid_load  = 1'b1;
          state_next = FULL;
        end else if (out_xfer) begin
          main_clear = 1'b1;
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer && skid_valid) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clear     = 1'b1;
          state_next     = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (flush) begin
      state_next = EMPTY;
      main_load  = 1'b0;
      skid_load  = 1'b0;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end
  end

  // in_ready is a flop so out_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != FULL);
    end
  end

  shift_pipe_slot #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_main (
    .clk        (clk),
    .rst        (rst),
    .clear      (main_clear),
    .load       (main_load),
    .load_data  (main_from_skid ? skid_data  : in_data),
    .load_shamt (main_from_skid ? skid_shamt : in_shamt),
    .load_zero  (main_from_skid ? skid_zero  : (in_data == '0)),
    .data       (out_data),
    .shamt      (out_shamt),
    .zero       (out_zero),
    .valid      (out_valid)
  );

  shift_pipe_slot #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .clear      (skid_clear),
    .load       (skid_load),
    .load_data  (in_data),
    .load_shamt (in_shamt),
    .load_zero  (in_data == '0),
    .data       (skid_data),
    .shamt      (skid_shamt),
    .zero       (skid_zero),
    .valid      (skid_valid)
  );

`ifdef SHIFT_PIPE_STATS_EN
  logic [15:0] count;

  // A transfer coinciding with flush is discarded and not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (out_xfer && !flush) begin
      count <= count + 16'd1;
    end
  end

  assign out_count = count;
`else
  assign out_count = '0;
`endif

endmodule

// File: tb/tb_shift_pipe_reg.sv
// Bench for shift_pipe_reg: directed scenarios plus randomized traffic against a queue model.
module tb_shift_pipe_reg;

  localparam int DW = 32;
  localparam int SW = 2;
`ifdef SHIFT_PIPE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [SW-1:0] in_shamt = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_shamt;
  logic          out_zero;
  logic [15:0]   out_count;

  shift_pipe_reg #(.DATA_W(DW), .SHAMT_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shamt (out_shamt),
    .out_zero  (out_zero),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_count = '0;
  int          m_xfers = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  // Reference: a FIFO of capacity two; inputs accepted only when fewer than two words held.
  function automatic logic exp_valid();
    return q.size() > 0;
  endfunction
  function automatic logic exp_ready();
    return q.size() < 2;
  endfunction
  function automatic logic [DW-1:0] exp_data();
    return (q.size() > 0) ? q[0].d : '0;
  endfunction
  function automatic logic [SW-1:0] exp_shamt();
    return (q.size() > 0) ? q[0].s : '0;
  endfunction
  function automatic logic exp_zero();
    return (q.size() > 0) ? (q[0].d == '0) : 1'b0;
  endfunction
  function automatic logic [15:0] exp_count();
    return STATS ? m_count : 16'h0;
  endfunction

  task automatic tick();
    bit in_x, out_x;
    in_x  = in_valid && (q.size() < 2);
    out_x = out_ready && (q.size() > 0);
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_count = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (out_x) begin
        void'(q.pop_front());
        m_count = m_count + 16'd1;
        m_xfers++;
      end
      if (in_x) q.push_back(ent_t'{d: in_data, s: in_shamt});
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h1234; out_ready = 1'b0;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b expected 1", in_ready); else n_pass++;
    n_checks++; if (out_data !== '0 || out_shamt !== '0 || out_zero !== 1'b0)
      $display("FAIL reset_outputs: got data=%0h shamt=%0h zero=%0b expected 0/0/0", out_data, out_shamt, out_zero); else n_pass++;
    n_checks++; if (out_count !== 16'h0) $display("FAIL reset_count: got %0h expected 0", out_count); else n_pass++;
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_latency();
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_shamt = 2'b10; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_shamt !== 2'b10 || out_zero !== 1'b0)
      $display("FAIL latency: got v=%0b d=%0h s=%0h z=%0b expected 1/deadbeef/2/0", out_valid, out_data, out_shamt, out_zero);
    else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_data !== '0) $display("FAIL latency_drain: got v=%0b d=%0h expected 0/0", out_valid, out_data); else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_shamt = 2'b01;
    in_data = 32'h1; tick();
    n_checks++; if (in_ready !== 1'b1 || out_data !== 32'h1) $display("FAIL bp_first: got rdy=%0b d=%0h expected 1/1", in_ready, out_data); else n_pass++;
    in_data = 32'h2; tick();
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_full: got in_ready=%0b expected 0", in_ready); else n_pass++;
    in_data = 32'h3; tick();
    n_checks++; if (in_ready !== 1'b0 || out_data !== 32'h1 || out_valid !== 1'b1)
      $display("FAIL bp_hold: got rdy=%0b d=%0h v=%0b expected 0/1/1", in_ready, out_data, out_valid); else n_pass++;
    in_valid = 1'b0; out_ready = 1'b1; tick();
    n_checks++; if (out_data !== 32'h2 || in_ready !== 1'b1) $display("FAIL bp_second: got d=%0h rdy=%0b expected 2/1", out_data, in_ready); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_no_third: got v=%0b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA; tick();
    out_ready = 1'b1; in_data = 32'hB; tick();
    in_valid = 1'b0;
    n_checks++; if (out_data !== 32'hB || out_valid !== 1'b1 || in_ready !== 1'b1)
      $display("FAIL simul: got d=%0h v=%0b rdy=%0b expected b/1/1", out_data, out_valid, in_ready); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL simul_single: got v=%0b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h11; tick();
    in_data = 32'h22; tick();
    flush = 1'b1; out_ready = 1'b1; in_data = 32'h33; tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_state: got v=%0b rdy=%0b expected 0/1", out_valid, in_ready); else n_pass++;
    n_checks++; if (out_count !== exp_count()) $display("FAIL flush_count: got %0h expected %0h", out_count, exp_count()); else n_pass++;
  endtask

  task automatic test_zero_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0; in_shamt = 2'b11; tick();
    n_checks++; if (out_zero !== 1'b1 || out_valid !== 1'b1) $display("FAIL zero_flag: got z=%0b v=%0b expected 1/1", out_zero, out_valid); else n_pass++;
    in_data = 32'h5; tick();
    rst = 1'b1; out_ready = 1'b1; tick();
    rst = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || out_shamt !== '0 || out_zero !== 1'b0 || out_count !== 16'h0)
      $display("FAIL reset_full: got v=%0b rdy=%0b d=%0h s=%0h z=%0b c=%0h expected 0/1/0/0/0/0",
               out_valid, in_ready, out_data, out_shamt, out_zero, out_count);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_data   = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      in_shamt  = SW'($urandom_range(0, 3));
      tick();
      n_checks++; if (out_valid !== exp_valid()) $display("FAIL rnd_valid[%0d]: got %0b expected %0b", i, out_valid, exp_valid()); else n_pass++;
      n_checks++; if (in_ready !== exp_ready()) $display("FAIL rnd_ready[%0d]: got %0b expected %0b", i, in_ready, exp_ready()); else n_pass++;
      n_checks++; if (out_data !== exp_data() || out_shamt !== exp_shamt())
        $display("FAIL rnd_data[%0d]: got %0h/%0h expected %0h/%0h", i, out_data, out_shamt, exp_data(), exp_shamt()); else n_pass++;
      n_checks++; if (out_zero !== exp_zero()) $display("FAIL rnd_zero[%0d]: got %0b expected %0b", i, out_zero, exp_zero()); else n_pass++;
      n_checks++; if (out_count !== exp_count()) $display("FAIL rnd_count[%0d]: got %0h expected %0h", i, out_count, exp_count()); else n_pass++;
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_count_wrap();
    rst = 1'b1; tick(); rst = 1'b0;
    m_xfers = 0;
    in_valid = 1'b1; out_ready = 1'b1; in_shamt = 2'b01;
    for (int i = 0; i < 70000 && m_xfers < 65535; i++) begin
      in_data = DW'(i);
      tick();
    end
    n_checks++; if (m_xfers != 65535) $display("FAIL wrap_budget: got %0d transfers expected 65535", m_xfers); else n_pass++;
    n_checks++; if (out_count !== (STATS ? 16'hFFFF : 16'h0)) $display("FAIL count_max: got %0h expected %0h", out_count, STATS ? 16'hFFFF : 16'h0); else n_pass++;
    in_data = 32'hCAFE; tick();
    n_checks++; if (out_count !== 16'h0) $display("FAIL count_wrap: got %0h expected 0", out_count); else n_pass++;
    n_checks++; if (out_data !== exp_data() || out_data !== 32'hCAFE) $display("FAIL wrap_data: got %0h expected cafe", out_data); else n_pass++;
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_zero_reset();
    test_random();
    test_count_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
